// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer, valid/ready
// input handshake, bit-rate enable, framing outputs and synchronous flush.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_serializer: WIDTH must be in 2..32");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // flush wins over a same-edge handshake, so the offered word is dropped.
  assign accept = in_valid && !hold_full_q && !flush;

  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shifter_d   = shifter_q;
    cnt_d       = cnt_q;

    if (flush) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shifter_d   = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt_q != LAST) begin
              shifter_d = MSB_FIRST ? (shifter_q << 1) : (shifter_q >> 1);
              cnt_d     = cnt_q + CW'(1);
            end else if (hold_full_q) begin
              // Reload straight from the buffer so the next word has no gap.
              shifter_d   = hold_q;
              cnt_d       = '0;
              hold_full_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // accept implies the buffer was empty, so it never collides with a reload.
      if (accept) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shifter_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shifter_q   <= shifter_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = !hold_full_q;
    ser_valid = 1'b0;
    ser_out   = IDLE_LEVEL;
    ser_last  = 1'b0;
    if (state_q == SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = MSB_FIRST ? shifter_q[WIDTH-1] : shifter_q[0];
      ser_last  = (cnt_q == LAST);
    end
    busy = (state_q == SHIFT) || hold_full_q;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer. It succeeds the fixed 4-bit load/shift register. Added over that block:
- configurable word width and bit order
- valid/ready input handshake with a one-word holding buffer, so consecutive words go out with no gap
- external bit-rate enable
- framing outputs (valid/last) and a synchronous flush

It sits between a parallel data source and a serial line driver or bit-rate generator.

Parameters:
WIDTH, 8, parallel word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 0, value driven on ser_out when no word is being sent.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort; drops the current word and the buffered word
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  parallel word
shift_en  input  1  bit-period tick; advances the serializer by one bit
ser_out  output  1  serial data
ser_valid  output  1  ser_out carries a data bit
ser_last  output  1  ser_out carries the final bit of the current word
busy  output  1  shifter active or holding buffer full

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clock.
- Reset state:
  - state = IDLE, hold_full = 0, shifter = 0, bit counter = 0
  - ser_out = IDLE_LEVEL, ser_valid = 0, ser_last = 0, busy = 0, in_ready = 1
- Storage:
  - WIDTH-bit holding register plus hold_full flag
  - WIDTH-bit shifter
  - counter cnt of $clog2(WIDTH) bits
- Handshake:
  - in_ready = !hold_full (combinational).
  - A word is accepted on a rising edge where in_valid && in_ready. It is written to the holding register and hold_full is set.
  - in_data is sampled only on the accepting edge.
- State IDLE:
  - If hold_full: on the next edge, copy hold to the shifter, set cnt = 0, clear hold_full, go to SHIFT.
  - No accept can coincide with that transfer, because in_ready = 0.
- State SHIFT:
  - ser_valid = 1.
  - ser_out = shifter[WIDTH-1] when MSB_FIRST = 1, else shifter[0].
  - ser_last = 1 when cnt == WIDTH-1.
  - Each bit is held until an edge where shift_en = 1. With shift_en tied high, one bit per cycle.
  - On shift_en with cnt < WIDTH-1: shift toward the output end (left if MSB_FIRST, else right), fill with 0, cnt++.
  - On shift_en with cnt == WIDTH-1 and hold_full = 1: load shifter from hold, cnt = 0, clear hold_full, stay in SHIFT. The next word's first bit follows the last bit with no idle gap.
  - On shift_en with cnt == WIDTH-1 and hold_full = 0: go to IDLE.
  - A new word may be accepted into hold at any time during SHIFT while hold_full = 0. This includes the edge where the last bit retires, provided hold was empty before that edge: the accepted word sets hold_full and is transferred from IDLE next cycle.
- Derived outputs:
  - IDLE: ser_out = IDLE_LEVEL, ser_valid = 0, ser_last = 0.
  - busy = (state == SHIFT) || hold_full.
- Latency: a word accepted at edge N has its first bit on ser_out after edge N+1 (from IDLE). Words buffered during SHIFT have zero gap.
- flush:
  - Highest priority after reset. On an edge with flush = 1: state = IDLE, hold_full = 0, cnt = 0.
  - An in_valid on the same edge is ignored (not accepted), even if in_ready = 1.
- shift_en in IDLE has no effect. shift_en may be low for arbitrarily long periods; outputs stay stable.
- Reset mid-word returns immediately to the reset state; the partial word is lost.
- Parameter outside WIDTH 2..32: elaboration error.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, shift_en=1. Send 4'b1011 -> ser_out = 1,0,1,1 on 4 consecutive cycles starting 2 edges after accept; ser_last on the 4th bit only; then ser_out = 0, ser_valid = 0.
2. WIDTH=8, MSB_FIRST=0. Send 0xA5 then 0x3C back-to-back -> 16 contiguous bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; ser_valid never drops; in_ready low while hold_full.
3. WIDTH=8, shift_en pulsed every 3rd cycle. Send 0xF0 -> each bit held exactly 3 cycles; ser_last held 3 cycles; 24 cycles total in SHIFT.
4. Fill shifter and hold, then keep in_valid high -> in_ready = 0 and no third word accepted until the first word's last bit retires; then in_ready = 1 and exactly one more word is accepted.
5. Assert flush mid-word with in_valid high -> next cycle ser_valid = 0, busy = 0, in_ready = 1; the word presented on the flush edge is not sent.
6. Assert reset asynchronously mid-word (between clock edges) with IDLE_LEVEL=1 -> ser_out = 1, ser_valid = 0, in_ready = 1 immediately; a new word after release is serialised correctly from bit 0.
